// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline buffer: valid/ready handshake with a 2-entry skid,
// synchronous flush, and control bits forced to zero whenever the head is not valid.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | nothing buffered, outputs show a bubble
//   ST_ONE   | main register holds the head entry
//   ST_TWO   | main holds the head, skid holds the next entry
module pipe_stage_buf #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              accept;
  logic              consume;

  // Ready and valid come straight from the state register, so no path exists
  // from out_ready to in_ready.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ST_ONE:  occupancy = 2'd1;
      ST_TWO:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      // Data is left in place; only the control bits must not leak downstream.
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (accept) begin
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = ST_TWO;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (consume) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            state_d     = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage buffer that replaces the fixed-field inter-stage flop banks with one generic stage. It carries a control bundle and a data payload from one pipeline stage to the next under a valid/ready handshake, with a 2-entry skid so that `in_ready` is purely registered. It adds synchronous flush and bubble squashing of control bits, which the fixed-field banks do not provide. One instance sits between each adjacent stage pair (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- `DATA_W`, 64, payload width in bits (instruction, ALU result, memory data, PCs, destination register, concatenated by the instantiating stage).
- `CTRL_W`, 4, control-bit width (for example halt, MemtoReg, RegWrite, SavePC); forced to 0 whenever the output is not valid.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-low: asserting it clears all state immediately, with no clock edge required.
- `flush`  input  1  synchronous squash of all buffered entries.
- `in_valid`  input  1  upstream holds a valid entry.
- `in_ready`  output  1  the buffer can accept an entry this cycle.
- `in_ctrl`  input  CTRL_W  upstream control bits.
- `in_data`  input  DATA_W  upstream payload.
- `out_valid`  output  1  `out_ctrl`/`out_data` hold a valid entry.
- `out_ready`  input  1  downstream consumes the entry this cycle.
- `out_ctrl`  output  CTRL_W  control bits of the head entry; all 0 when `out_valid`=0.
- `out_data`  output  DATA_W  payload of the head entry; holds its last value when `out_valid`=0.
- `occupancy`  output  2  number of buffered entries (0..2).

## Operation
- Storage:
  - main register (head) drives the outputs;
  - skid register catches one entry while downstream stalls.
- States: EMPTY (occ 0), ONE (main full), TWO (main and skid full).
- Handshake definitions:
  - accept = `in_valid` & `in_ready`;
  - consume = `out_valid` & `out_ready`.
- Output and ready decoding:
  - `in_ready` = (state != TWO), decoded from the state register only; there is no combinational path from `out_ready`.
  - `out_valid` = (state != EMPTY).
- Transitions, when `flush`=0:
  - EMPTY: on accept, main ← in, go to ONE.
  - ONE, accept & consume: main ← in, stay in ONE.
  - ONE, accept & !consume: skid ← in, go to TWO.
  - ONE, !accept & consume: go to EMPTY.
  - ONE, otherwise: hold.
  - TWO, consume: main ← skid, go to ONE. No accept is possible in TWO.
  - TWO, otherwise: hold.
- Ordering: entries leave strictly in arrival order. No entry is duplicated or dropped, except on flush.
- Flush:
  - Highest priority: the next state is EMPTY and the main and skid ctrl fields clear to 0.
  - An entry offered in the flush cycle is dropped, even though `in_ready`=1.
  - Data fields are not cleared.
- Bubble: while `out_valid`=0, `out_ctrl` is driven to 0. This gates RegWrite, MemWrite and halt in downstream logic without extra decode.
- Reset (`rst`=0):
  - state = EMPTY; main and skid data and ctrl = 0;
  - `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0, `in_ready`=1.
  - Reset applied mid-transfer discards all entries.

## Timing
- Latency: an accepted entry appears on the outputs one cycle after the accepting edge, when entering an EMPTY or draining ONE buffer.
- Throughput: 1 entry/cycle sustained while `out_ready`=1.
- Stall response:
  - when `out_ready` falls, one further entry is absorbed by the skid;
  - `in_ready` falls the cycle after the skid fills.
- Resume: when `out_ready` rises in TWO, the skid entry reaches the head at the next edge and `in_ready` returns high in that same cycle.
- `flush` takes effect at the next rising edge: `out_valid`=0 and `out_ctrl`=0 in the following cycle.
- Reset release: the first accept can occur at the first rising edge after `rst` deasserts.

## Test plan
- Reset: hold `rst`=0 with random inputs toggling.
  - Required: `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0, `in_ready`=1.
  - Assert `rst` low asynchronously between edges while in TWO: outputs clear immediately.
- Streaming: `out_ready`=1, feed data 0x1..0x8 on consecutive cycles with ctrl=4'b0100.
  - Required: each value appears one cycle later, in order, with ctrl=4'b0100, `occupancy`=1 throughout.
- Stall and skid: stream 0xA, 0xB, 0xC, dropping `out_ready` in the cycle that 0xA is at the head.
  - Required: 0xB is captured in the skid, `occupancy`=2, `in_ready`=0, and 0xC is held upstream.
  - Raise `out_ready`: output sequence is 0xA, 0xB, 0xC with no loss or duplication.
- Flush in TWO with `in_valid`=1, ctrl=4'b1111.
  - Required: next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0, and the offered entry is dropped.
  - The following entry, 0x55, emerges normally.
- Bubble: `in_valid`=0 for 3 cycles, then 0x77 with ctrl=4'b0010.
  - Required: `out_ctrl`=0 during the gap, and `out_data` holds the previous value.
- Randomised `in_valid`/`out_ready` over 10k cycles, checked against a reference queue model.
  - Required: order is preserved, occupancy never exceeds 2, and no entry is lost.
